// File: rtl/krms_scale_apply.sv
// krms_scale_apply: applies the per-row K-RMS scale to a streamed int8 row.
// Two-stage multiply / round-shift-saturate datapath behind a small row FSM.
module krms_scale_apply #(
  parameter int BUS_NUM        = 8,
  parameter int DATA_NUM_WIDTH = 10,
  parameter int SCALE_WIDTH    = 24,
  parameter int SHIFT_WIDTH    = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_vld,
  input  logic [DATA_NUM_WIDTH-1:0] cfg_k,
  input  logic [SHIFT_WIDTH-1:0]    cfg_shift,
  input  logic                      start,
  input  logic [SCALE_WIDTH-1:0]    rc_scale,
  input  logic                      rc_scale_vld,
  input  logic [BUS_NUM*8-1:0]      in_fixed_data,
  input  logic                      in_fixed_data_vld,
  output logic                      in_fixed_data_rdy,
  output logic [BUS_NUM*8-1:0]      out_fixed_data,
  output logic                      out_fixed_data_vld,
  output logic                      done
);

  localparam int PW = SCALE_WIDTH + 9;
  localparam int CW = DATA_NUM_WIDTH + 1;

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] WAIT_SCALE = 2'd1;
  localparam logic [1:0] APPLY      = 2'd2;
  localparam logic [1:0] DRAIN      = 2'd3;

  logic [1:0]                state;
  logic [1:0]                state_nx;
  logic [DATA_NUM_WIDTH-1:0] k_r;
  logic [SHIFT_WIDTH-1:0]    shift_r;
  logic [SCALE_WIDTH-1:0]    scale_r;
  logic [CW-1:0]             elem_cnt;
  logic [CW:0]               cnt_next;
  logic                      accept;
  logic                      last_beat;
  logic                      row_go;
  logic                      cap_scale;

  logic                      s1_vld;
  logic                      s1_last;
  logic [BUS_NUM*PW-1:0]     prod_bus;
  logic [BUS_NUM*PW-1:0]     s1_prod;
  logic [BUS_NUM*8-1:0]      sat_bus;

  assign in_fixed_data_rdy = (state == APPLY);
  assign accept    = in_fixed_data_rdy & in_fixed_data_vld;
  assign cnt_next  = {1'b0, elem_cnt} + (CW+1)'(BUS_NUM);
  assign last_beat = (cnt_next >= {2'b00, k_r});
  assign row_go    = start && (k_r != '0);
  assign cap_scale = rc_scale_vld &&
                     (((state == IDLE) && row_go) ||
                      (state == WAIT_SCALE));

  // row sequencing
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (row_go)
          state_nx = rc_scale_vld ? APPLY : WAIT_SCALE;
      WAIT_SCALE:
        if (rc_scale_vld) state_nx = APPLY;
      APPLY:
        if (accept && last_beat) state_nx = DRAIN;
      DRAIN:
        if (s1_vld && s1_last) state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  // state, config, scale and element counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      k_r      <= '0;
      shift_r  <= '0;
      scale_r  <= '0;
      elem_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && cfg_vld) begin
        k_r     <= cfg_k;
        shift_r <= cfg_shift;
      end
      if (cap_scale) scale_r <= rc_scale;
      if (state_nx == IDLE)
        elem_cnt <= '0;
      else if (accept)
        elem_cnt <= cnt_next[CW-1:0];
    end
  end

  for (genvar g = 0; g < BUS_NUM; g++) begin : g_lane
    logic signed [PW-1:0] a;
    logic signed [PW-1:0] b;
    logic signed [PW-1:0] p;
    logic signed [PW:0]   rnd;
    logic signed [PW:0]   shr;
    logic signed [PW:0]   half;
    logic [CW:0]          idx;

    assign a    = PW'($signed(in_fixed_data[g*8 +: 8]));
    assign b    = $signed({{(PW-SCALE_WIDTH){1'b0}}, scale_r});
    assign idx  = {1'b0, elem_cnt} + (CW+1)'(g);
    assign p    = (idx < {2'b00, k_r}) ? a * b : '0;
    assign prod_bus[g*PW +: PW] = p;

    assign half = (shift_r != '0) ?
                  $signed((PW+1)'(1) << (shift_r - 1'b1)) : '0;
    assign rnd  = $signed({s1_prod[g*PW+PW-1], s1_prod[g*PW +: PW]}) + half;
    assign shr  = rnd >>> shift_r;

    // saturate the shifted lane into int8
    always_comb begin
      if (shr > $signed((PW+1)'(127)))
        sat_bus[g*8 +: 8] = 8'h7f;
      else if (shr < -$signed((PW+1)'(128)))
        sat_bus[g*8 +: 8] = 8'h80;
      else
        sat_bus[g*8 +: 8] = shr[7:0];
    end
  end

  // stage 1: multiply accepted beat by the row scale
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_last <= 1'b0;
      s1_prod <= '0;
    end else begin
      s1_vld  <= accept;
      s1_last <= accept & last_beat;
      if (accept) s1_prod <= prod_bus;
    end
  end

  // stage 2: register rounded/saturated lanes, hold when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_fixed_data     <= '0;
      out_fixed_data_vld <= 1'b0;
      done               <= 1'b0;
    end else begin
      out_fixed_data_vld <= s1_vld;
      done               <= s1_vld & s1_last;
      if (s1_vld) out_fixed_data <= sat_bus;
    end
  end

endmodule

// File: tb/tb_krms_scale_apply.sv
// tb_krms_scale_apply: directed vectors for krms_scale_apply.
// Inputs change 1ns after posedge, outputs checked at the same point.
module tb_krms_scale_apply;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_vld;
  logic [9:0]  cfg_k;
  logic [4:0]  cfg_shift;
  logic        start;
  logic [23:0] rc_scale;
  logic        rc_scale_vld;
  logic [63:0] in_fixed_data;
  logic        in_fixed_data_vld;
  logic        in_fixed_data_rdy;
  logic [63:0] out_fixed_data;
  logic        out_fixed_data_vld;
  logic        done;

  int n_vec = 0;
  int n_err = 0;

  krms_scale_apply dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .cfg_vld            (cfg_vld),
    .cfg_k              (cfg_k),
    .cfg_shift          (cfg_shift),
    .start              (start),
    .rc_scale           (rc_scale),
    .rc_scale_vld       (rc_scale_vld),
    .in_fixed_data      (in_fixed_data),
    .in_fixed_data_vld  (in_fixed_data_vld),
    .in_fixed_data_rdy  (in_fixed_data_rdy),
    .out_fixed_data     (out_fixed_data),
    .out_fixed_data_vld (out_fixed_data_vld),
    .done               (done)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pk(
    input int a0, input int a1, input int a2, input int a3,
    input int a4, input int a5, input int a6, input int a7);
    return {8'(a7), 8'(a6), 8'(a5), 8'(a4),
            8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input int k, input int sh);
    cfg_vld   = 1'b1;
    cfg_k     = 10'(k);
    cfg_shift = 5'(sh);
    step();
    cfg_vld   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    cfg_vld = 0; cfg_k = 0; cfg_shift = 0;
    start = 0; rc_scale = 0; rc_scale_vld = 0;
    in_fixed_data = 0; in_fixed_data_vld = 0;
    #1;
    chk("rst_data", out_fixed_data, 64'h0);
    chk("rst_vld", 64'(out_fixed_data_vld), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_rdy", 64'(in_fixed_data_rdy), 64'h0);
    step(); step();
    rst_n = 1'b1;
    step();

    // row 1: unity scale, beat offered during WAIT_SCALE
    cfg(8, 16);
    start = 1; step(); start = 0;
    in_fixed_data = pk(9, 9, 9, 9, 9, 9, 9, 9);
    in_fixed_data_vld = 1;
    chk("wait_rdy", 64'(in_fixed_data_rdy), 64'h0);
    step();
    in_fixed_data_vld = 0;
    rc_scale = 24'h010000; rc_scale_vld = 1;
    step(); rc_scale_vld = 0;
    chk("wait_no_out", 64'(out_fixed_data_vld), 64'h0);
    chk("apply_rdy", 64'(in_fixed_data_rdy), 64'h1);
    in_fixed_data = pk(1, -1, 127, -128, 0, 5, -5, 64);
    in_fixed_data_vld = 1;
    step(); in_fixed_data_vld = 0;
    chk("r1_rdy_low", 64'(in_fixed_data_rdy), 64'h0);
    chk("r1_lat1", 64'(out_fixed_data_vld), 64'h0);
    step();
    chk("r1_vld", 64'(out_fixed_data_vld), 64'h1);
    chk("r1_data", out_fixed_data, pk(1, -1, 127, -128, 0, 5, -5, 64));
    chk("r1_done", 64'(done), 64'h1);
    step();
    chk("r1_vld_off", 64'(out_fixed_data_vld), 64'h0);
    chk("r1_hold", out_fixed_data, pk(1, -1, 127, -128, 0, 5, -5, 64));
    chk("r1_done_off", 64'(done), 64'h0);

    // row 2: scale 1.5 with start and scale in same cycle
    start = 1; rc_scale = 24'h018000; rc_scale_vld = 1;
    step(); start = 0; rc_scale_vld = 0;
    chk("r2_direct_apply", 64'(in_fixed_data_rdy), 64'h1);
    in_fixed_data = pk(10, -3, 100, -100, 1, -1, 2, -2);
    in_fixed_data_vld = 1;
    step(); in_fixed_data_vld = 0;
    step();
    chk("r2_data", out_fixed_data, pk(15, -4, 127, -128, 2, -1, 3, -3));
    chk("r2_done", 64'(done), 64'h1);
    step();

    // row 3: K=20, three beats with gaps, late scale ignored
    cfg(20, 16);
    start = 1; step(); start = 0;
    rc_scale = 24'h010000; rc_scale_vld = 1;
    step(); rc_scale_vld = 0;
    in_fixed_data = pk(1, 2, 3, 4, 5, 6, 7, 8);
    in_fixed_data_vld = 1;
    step(); in_fixed_data_vld = 0;
    chk("r3_rdy_b1", 64'(in_fixed_data_rdy), 64'h1);
    rc_scale = 24'h020000; rc_scale_vld = 1;
    step(); rc_scale_vld = 0;
    chk("r3_b1_vld", 64'(out_fixed_data_vld), 64'h1);
    chk("r3_b1_data", out_fixed_data, pk(1, 2, 3, 4, 5, 6, 7, 8));
    chk("r3_b1_done", 64'(done), 64'h0);
    in_fixed_data = pk(-1, -2, -3, -4, -5, -6, -7, -8);
    in_fixed_data_vld = 1;
    step(); in_fixed_data_vld = 0;
    step();
    chk("r3_b2_data", out_fixed_data,
        pk(-1, -2, -3, -4, -5, -6, -7, -8));
    chk("r3_b2_done", 64'(done), 64'h0);
    in_fixed_data = pk(9, 10, 11, 12, 13, 14, 15, 16);
    in_fixed_data_vld = 1;
    step(); in_fixed_data_vld = 0;
    chk("r3_rdy_low", 64'(in_fixed_data_rdy), 64'h0);
    step();
    chk("r3_b3_vld", 64'(out_fixed_data_vld), 64'h1);
    chk("r3_b3_data", out_fixed_data, pk(9, 10, 11, 12, 0, 0, 0, 0));
    chk("r3_b3_done", 64'(done), 64'h1);
    step();

    // row 4: shift 0, scale 2 saturation; cfg during APPLY ignored
    cfg(8, 0);
    start = 1; rc_scale = 24'h000002; rc_scale_vld = 1;
    step(); start = 0; rc_scale_vld = 0;
    cfg(16, 3);
    in_fixed_data = pk(70, -70, 63, -64, 1, -1, 0, -65);
    in_fixed_data_vld = 1;
    step(); in_fixed_data_vld = 0;
    step();
    chk("r4_data", out_fixed_data,
        pk(127, -128, 126, -128, 2, -2, 0, -128));
    chk("r4_done", 64'(done), 64'h1);
    step();

    // K=0 start ignored
    cfg(0, 16);
    start = 1; rc_scale = 24'h010000; rc_scale_vld = 1;
    in_fixed_data_vld = 1;
    step(); start = 0; rc_scale_vld = 0;
    chk("k0_rdy", 64'(in_fixed_data_rdy), 64'h0);
    step(); step();
    in_fixed_data_vld = 0;
    chk("k0_no_out", 64'(out_fixed_data_vld), 64'h0);
    chk("k0_hold", out_fixed_data,
        pk(127, -128, 126, -128, 2, -2, 0, -128));

    // reset mid-APPLY
    cfg(16, 16);
    start = 1; rc_scale = 24'h010000; rc_scale_vld = 1;
    step(); start = 0; rc_scale_vld = 0;
    in_fixed_data = pk(4, 4, 4, 4, 4, 4, 4, 4);
    in_fixed_data_vld = 1;
    step(); in_fixed_data_vld = 0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_data", out_fixed_data, 64'h0);
    chk("mid_rst_vld", 64'(out_fixed_data_vld), 64'h0);
    chk("mid_rst_rdy", 64'(in_fixed_data_rdy), 64'h0);
    step();
    chk("mid_rst_done", 64'(done), 64'h0);
    rst_n = 1'b1;
    step();
    chk("post_rst_vld", 64'(out_fixed_data_vld), 64'h0);

    // row after reset
    cfg(8, 16);
    start = 1; rc_scale = 24'h010000; rc_scale_vld = 1;
    step(); start = 0; rc_scale_vld = 0;
    in_fixed_data = pk(3, -3, 50, -50, 7, -7, 100, -100);
    in_fixed_data_vld = 1;
    step(); in_fixed_data_vld = 0;
    step();
    chk("r5_vld", 64'(out_fixed_data_vld), 64'h1);
    chk("r5_data", out_fixed_data, pk(3, -3, 50, -50, 7, -7, 100, -100));
    chk("r5_done", 64'(done), 64'h1);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
